// File: rtl/br_load_sequencer_if.sv
// br_load_sequencer_if: request/ack handshake and BR strobe bundle for br_load_sequencer
// master: requester side (drives mem_req/mem_mod/tr_req/tr_syl, observes the rest)
// slave : sequencer side (drives acks, sa_strobe, AnCBRVN, AnSBRYV, AnSBRZV, busy, br_valid)
interface br_load_sequencer_if;
  logic       mem_req;
  logic [1:0] mem_mod;
  logic       mem_ack;
  logic       tr_req;
  logic [1:0] tr_syl;
  logic       tr_ack;
  logic [3:0] sa_strobe;
  logic       AnCBRVN;
  logic       AnSBRYV;
  logic       AnSBRZV;
  logic       busy;
  logic       br_valid;
  modport master (
    output mem_req, mem_mod, tr_req, tr_syl,
    input  mem_ack, tr_ack, sa_strobe, AnCBRVN, AnSBRYV, AnSBRZV, busy, br_valid
  );
  modport slave (
    input  mem_req, mem_mod, tr_req, tr_syl,
    output mem_ack, tr_ack, sa_strobe, AnCBRVN, AnSBRYV, AnSBRZV, busy, br_valid
  );
endinterface

// File: rtl/br_load_sequencer.sv
// br_load_sequencer: arbitrates memory/TR loads into BR and sequences clear, load, settle, ack
// Ports: clk (rising edge), reset (sync, active-high), bus (br_load_sequencer_if.slave)
// Params: CLR_CYCLES (1-3) clear pulse length, SETTLE_CYCLES (0-7) wait after the load strobe
// Macro BR_SYLLABLE_SELECT_EN: honour tr_syl per half; undefined loads both halves on every TR op
module br_load_sequencer #(
  parameter int CLR_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  br_load_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_SETTLE, S_ACK} state_t;
  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt;
  logic [1:0] r_op;
  logic       r_is_tr, r_last_tr, r_full, r_br_valid;
  logic       w_grant, w_grant_mem, w_tr_empty, w_syl_y, w_syl_z;
  assign w_grant     = bus.mem_req | bus.tr_req;
  // mem wins unless TR also asks and mem was served last
  assign w_grant_mem = bus.mem_req & (~bus.tr_req | r_last_tr);
`ifdef BR_SYLLABLE_SELECT_EN
  assign w_tr_empty = bus.tr_syl == 2'b00;
  assign w_syl_y    = r_op[1];
  assign w_syl_z    = r_op[0];
`else
  assign w_tr_empty = 1'b0;
  assign w_syl_y    = 1'b1;
  assign w_syl_z    = 1'b1;
`endif
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      S_IDLE: if (w_grant) begin
        // an empty TR syllable select has nothing to clear or load
        w_next = (!w_grant_mem && w_tr_empty) ? S_ACK : S_CLR;
        w_cnt  = 3'd0;
      end
      S_CLR: if (r_cnt == 3'(CLR_CYCLES - 1)) w_next = S_LOAD;
        else w_cnt = r_cnt + 3'd1;
      S_LOAD: begin
        w_next = (SETTLE_CYCLES == 0) ? S_ACK : S_SETTLE;
        w_cnt  = 3'd0;
      end
      S_SETTLE: if (r_cnt == 3'(SETTLE_CYCLES - 1)) w_next = S_ACK;
        else w_cnt = r_cnt + 3'd1;
      default: w_next = S_IDLE;
    endcase
    bus.sa_strobe = (r_state == S_LOAD && !r_is_tr) ? 4'b0001 << r_op : 4'b0000;
    bus.AnCBRVN   = r_state != S_CLR;
    bus.AnSBRYV   = r_state == S_LOAD && r_is_tr && w_syl_y;
    bus.AnSBRZV   = r_state == S_LOAD && r_is_tr && w_syl_z;
    bus.mem_ack   = r_state == S_ACK && !r_is_tr;
    bus.tr_ack    = r_state == S_ACK && r_is_tr;
    bus.busy      = r_state != S_IDLE;
    bus.br_valid  = r_br_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_op       <= 2'd0;
      r_is_tr    <= 1'b0;
      r_last_tr  <= 1'b1;
      r_full     <= 1'b0;
      r_br_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (r_state == S_IDLE && w_grant) begin
        r_is_tr <= ~w_grant_mem;
        r_op    <= w_grant_mem ? bus.mem_mod : bus.tr_syl;
        r_full  <= w_grant_mem | ~w_tr_empty;
      end
      if (r_state == S_IDLE && w_next == S_CLR) r_br_valid <= 1'b0;
      if (r_state == S_ACK) begin
        r_last_tr  <= r_is_tr;
        r_br_valid <= r_br_valid | r_full;
      end
    end
  end
endmodule

// File: tb/tb_br_load_sequencer.sv
// tb_br_load_sequencer: directed checks of br_load_sequencer at default and CLR=3/SETTLE=0 settings
module tb_br_load_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  br_load_sequencer_if ba ();
  br_load_sequencer_if bb ();
  br_load_sequencer u_a (.clk(clk), .reset(reset), .bus(ba));
  br_load_sequencer #(.CLR_CYCLES(3), .SETTLE_CYCLES(0)) u_b (.clk(clk), .reset(reset), .bus(bb));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic excl(logic ncbr, logic [3:0] sa, logic y, logic z, logic ma, logic ta);
    int n;
    n = int'(!ncbr) + int'(sa != 4'd0) + int'(y | z);
    return (n > 1) || ($countones(sa) > 1) || (ma && ta);
  endfunction
  always @(negedge clk) begin
    chk("excl_a", excl(ba.AnCBRVN, ba.sa_strobe, ba.AnSBRYV, ba.AnSBRZV, ba.mem_ack, ba.tr_ack), 0);
    chk("excl_b", excl(bb.AnCBRVN, bb.sa_strobe, bb.AnSBRYV, bb.AnSBRZV, bb.mem_ack, bb.tr_ack), 0);
  end
  task automatic mem_op(input logic [1:0] mod);
    logic [3:0] exp_sa;
    exp_sa = 4'b0001 << mod;
    ba.mem_req = 1'b1;
    ba.mem_mod = mod;
    step();
    chk("mem_clr_n", ba.AnCBRVN, 0);
    chk("mem_clr_valid", ba.br_valid, 0);
    chk("mem_clr_busy", ba.busy, 1);
    step();
    chk("mem_load_sa", ba.sa_strobe, exp_sa);
    chk("mem_load_clr_n", ba.AnCBRVN, 1);
    step();
    chk("mem_settle_sa", ba.sa_strobe, 0);
    chk("mem_settle_ack", ba.mem_ack, 0);
    step();
    chk("mem_ack", ba.mem_ack, 1);
    chk("mem_ack_tr", ba.tr_ack, 0);
    ba.mem_req = 1'b0;
    step();
    chk("mem_done_valid", ba.br_valid, 1);
    chk("mem_done_ack", ba.mem_ack, 0);
    chk("mem_done_busy", ba.busy, 0);
  endtask
  task automatic tr_op(input logic [1:0] syl, input logic y, input logic z);
    ba.tr_req = 1'b1;
    ba.tr_syl = syl;
    step();
    chk("tr_clr_n", ba.AnCBRVN, 0);
    ba.tr_req = 1'b0;
    step();
    chk("tr_load_y", ba.AnSBRYV, y);
    chk("tr_load_z", ba.AnSBRZV, z);
    chk("tr_load_sa", ba.sa_strobe, 0);
    step();
    chk("tr_settle_ack", ba.tr_ack, 0);
    step();
    chk("tr_ack", ba.tr_ack, 1);
    chk("tr_ack_mem", ba.mem_ack, 0);
    step();
    chk("tr_done_valid", ba.br_valid, 1);
    chk("tr_done_busy", ba.busy, 0);
  endtask
  initial begin
    logic [7:0] hist;
    int         n_ack;
    ba.mem_req = 1'b0; ba.mem_mod = 2'd0; ba.tr_req = 1'b0; ba.tr_syl = 2'd0;
    bb.mem_req = 1'b0; bb.mem_mod = 2'd0; bb.tr_req = 1'b0; bb.tr_syl = 2'd0;
    step();
    step();
    chk("rst_busy", ba.busy, 0);
    chk("rst_clr_n", ba.AnCBRVN, 1);
    chk("rst_sa", ba.sa_strobe, 0);
    chk("rst_y", ba.AnSBRYV, 0);
    chk("rst_z", ba.AnSBRZV, 0);
    chk("rst_mem_ack", ba.mem_ack, 0);
    chk("rst_tr_ack", ba.tr_ack, 0);
    chk("rst_valid", ba.br_valid, 0);
    reset = 1'b0;
    step();
    mem_op(2'd2);
    mem_op(2'd0);
    mem_op(2'd3);
`ifdef BR_SYLLABLE_SELECT_EN
    tr_op(2'b10, 1'b1, 1'b0);
    tr_op(2'b01, 1'b0, 1'b1);
    ba.tr_req = 1'b1;
    ba.tr_syl = 2'b00;
    step();
    chk("tr0_ack", ba.tr_ack, 1);
    chk("tr0_clr_n", ba.AnCBRVN, 1);
    chk("tr0_busy", ba.busy, 1);
    ba.tr_req = 1'b0;
    step();
    chk("tr0_done_ack", ba.tr_ack, 0);
    chk("tr0_valid", ba.br_valid, 1);
    chk("tr0_done_busy", ba.busy, 0);
`else
    tr_op(2'b01, 1'b1, 1'b1);
    tr_op(2'b00, 1'b1, 1'b1);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    hist = 8'd0;
    n_ack = 0;
    ba.mem_req = 1'b1; ba.mem_mod = 2'd1;
    ba.tr_req = 1'b1; ba.tr_syl = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ba.mem_ack) begin hist = {hist[5:0], 2'b01}; n_ack++; end
      if (ba.tr_ack) begin hist = {hist[5:0], 2'b10}; n_ack++; end
    end
    chk("tie_order", hist, 8'b01100110);
    chk("tie_count", n_ack, 4);
    ba.mem_req = 1'b0;
    ba.tr_req = 1'b0;
    step();
    step();
    step();
    step();
    step();
    chk("tie_idle", ba.busy, 0);
    ba.mem_req = 1'b1;
    ba.mem_mod = 2'd1;
    step();
    step();
    chk("abort_load_sa", ba.sa_strobe, 4'b0010);
    reset = 1'b1;
    ba.mem_req = 1'b0;
    step();
    chk("abort_sa", ba.sa_strobe, 0);
    chk("abort_clr_n", ba.AnCBRVN, 1);
    chk("abort_busy", ba.busy, 0);
    chk("abort_valid", ba.br_valid, 0);
    chk("abort_ack", ba.mem_ack, 0);
    reset = 1'b0;
    step();
    chk("abort_ack1", ba.mem_ack, 0);
    step();
    chk("abort_ack2", ba.mem_ack, 0);
    chk("abort_idle", ba.busy, 0);
    bb.mem_req = 1'b1;
    bb.mem_mod = 2'd3;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("b_clr_n", bb.AnCBRVN, 0);
      chk("b_clr_sa", bb.sa_strobe, 0);
    end
    step();
    chk("b_load_sa", bb.sa_strobe, 4'b1000);
    chk("b_load_clr_n", bb.AnCBRVN, 1);
    step();
    chk("b_ack", bb.mem_ack, 1);
    bb.mem_req = 1'b0;
    step();
    chk("b_done_ack", bb.mem_ack, 0);
    chk("b_done_valid", bb.br_valid, 1);
    chk("b_done_busy", bb.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
